// File: rtl/tcdm_mem_responder_pkg.sv
// Shared types and address decode for the word-interleaved TCDM responder.
package tcdm_mem_responder_package;

  localparam int unsigned BANK_SEL_LSB = 2;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
  } tcdm_req_t;

  typedef struct packed {
    int unsigned bank;
    int unsigned row;
  } bank_row_t;

  // Word-interleaved: low word bits pick the bank, the next bits pick the row.
  function automatic bank_row_t addr_decode(input logic [31:0] add,
                                            input int unsigned nb,
                                            input int unsigned bank_words);
    bank_row_t res;
    res.bank = (add >> BANK_SEL_LSB) & (nb - 1);
    res.row  = (add >> (BANK_SEL_LSB + $clog2(nb))) & (bank_words - 1);
    return res;
  endfunction

endpackage

// File: rtl/tcdm_mem_responder_if.sv
// TCDM bus bundle for MP ports; master drives requests, slave answers.
interface tcdm_mem_responder_if #(
  parameter int unsigned MP = 3
) ();
  logic [MP-1:0]       req;
  logic [MP-1:0]       gnt;
  logic [MP-1:0][31:0] add;
  logic [MP-1:0]       wen;
  logic [MP-1:0][3:0]  be;
  logic [MP-1:0][31:0] data;
  logic [MP-1:0][31:0] r_data;
  logic [MP-1:0]       r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tcdm_mem_responder_bank.sv
// One memory bank: round-robin arbiter over MP ports, byte-enable storage, read port.
module tcdm_mem_responder_bank
  import tcdm_mem_responder_package::*;
#(
  parameter int unsigned MP         = 3,
  parameter int unsigned NB         = 4,
  parameter int unsigned BANK_WORDS = 256
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [MP-1:0]   elig_i,
  input  tcdm_req_t       req_i [MP],
  output logic [MP-1:0]   gnt_o,
  output logic [31:0]     rdata_o
);
  localparam int unsigned PW = (MP > 1) ? $clog2(MP) : 1;
  localparam int unsigned RW = (BANK_WORDS > 1) ? $clog2(BANK_WORDS) : 1;

  logic [PW-1:0] rr_q, rr_d, win;
  logic          any;
  int unsigned   idx;
  tcdm_req_t     wreq;
  bank_row_t     dec;
  logic [RW-1:0] row;
  logic [31:0]   mem_q [BANK_WORDS];

  always_comb begin
    any   = 1'b0;
    win   = '0;
    idx   = 0;
    gnt_o = '0;
    for (int unsigned k = 0; k < MP; k++) begin
      idx = (32'(rr_q) + k) % MP;
      if (!any && elig_i[idx]) begin
        any = 1'b1;
        win = PW'(idx);
      end
    end
    if (any) gnt_o[win] = 1'b1;
    rr_d    = any ? PW'((32'(win) + 1) % MP) : rr_q;
    wreq    = req_i[win];
    dec     = addr_decode(wreq.add, NB, BANK_WORDS);
    row     = RW'(dec.row);
    rdata_o = mem_q[row];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_q <= '0;
    else       rr_q <= rr_d;
  end

  // Storage is intentionally outside reset: writes granted before reset stick.
  always_ff @(posedge clk_i) begin
    if (any && !wreq.wen) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wreq.be[i]) mem_q[row][8*i +: 8] <= wreq.data[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/tcdm_mem_responder.sv
// Multi-port word-interleaved TCDM memory: per-bank arbitration, 1-cycle response.
module tcdm_mem_responder
  import tcdm_mem_responder_package::*;
#(
  parameter int unsigned MP         = 3,
  parameter int unsigned NB         = 4,
  parameter int unsigned BANK_WORDS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [MP-1:0]        stall_i,
  tcdm_mem_responder_if.slave  tcdm
);
  localparam int unsigned NBW = (NB > 1) ? $clog2(NB) : 1;

  logic [NBW-1:0]      bank_sel [MP];
  tcdm_req_t           preq [MP];
  bank_row_t           dec;
  logic [MP-1:0]       elig [NB];
  logic [MP-1:0]       bank_gnt [NB];
  logic [31:0]         bank_rdata [NB];
  logic [MP-1:0]       gnt;
  logic [MP-1:0]       r_valid_q, r_valid_d;
  logic [MP-1:0][31:0] r_data_q, r_data_d;

  always_comb begin
    dec = '0;
    for (int unsigned b = 0; b < NB; b++) elig[b] = '0;
    for (int unsigned p = 0; p < MP; p++) begin
      preq[p] = '{add: tcdm.add[p], wen: tcdm.wen[p], be: tcdm.be[p], data: tcdm.data[p]};
      dec     = addr_decode(tcdm.add[p], NB, BANK_WORDS);
      bank_sel[p] = NBW'(dec.bank);
      elig[bank_sel[p]][p] = tcdm.req[p] & ~stall_i[p] & ~rst_i;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    tcdm_mem_responder_bank #(
      .MP        (MP),
      .NB        (NB),
      .BANK_WORDS(BANK_WORDS)
    ) u_bank (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .elig_i (elig[b]),
      .req_i  (preq),
      .gnt_o  (bank_gnt[b]),
      .rdata_o(bank_rdata[b])
    );
  end

  always_comb begin
    gnt = '0;
    for (int unsigned b = 0; b < NB; b++) gnt |= bank_gnt[b];
    r_valid_d = gnt;
    r_data_d  = r_data_q;
    for (int unsigned p = 0; p < MP; p++) begin
      if (gnt[p]) r_data_d[p] = preq[p].wen ? bank_rdata[bank_sel[p]] : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid_q <= '0;
      r_data_q  <= '0;
    end else begin
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
    end
  end

  assign tcdm.gnt     = gnt;
  assign tcdm.r_valid = r_valid_q;
  assign tcdm.r_data  = r_data_q;

endmodule

// File: tb/tb_tcdm_mem_responder.sv
// Directed bench for tcdm_mem_responder with hand-computed expectations.
module tb_tcdm_mem_responder;
  localparam int unsigned MP = 3;

  logic          clk;
  logic          rst;
  logic [MP-1:0] stall;
  int unsigned   total;
  int unsigned   bad;
  logic [31:0]   exp_val [MP];
  logic [2:0]    onehot;
  int unsigned   w;

  tcdm_mem_responder_if #(.MP(MP)) tcdm ();

  tcdm_mem_responder #(
    .MP        (MP),
    .NB        (4),
    .BANK_WORDS(256)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .stall_i(stall),
    .tcdm   (tcdm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setp(input int unsigned p, input logic rq, input logic [31:0] a,
                      input logic wn, input logic [3:0] b, input logic [31:0] d);
    tcdm.req[p]  = rq;
    tcdm.add[p]  = a;
    tcdm.wen[p]  = wn;
    tcdm.be[p]   = b;
    tcdm.data[p] = d;
  endtask

  task automatic idle_all();
    for (int unsigned p = 0; p < MP; p++) setp(p, 1'b0, '0, 1'b1, '0, '0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    stall = '0;
    idle_all();
    setp(0, 1'b1, 32'h0, 1'b1, 4'hF, '0);
    #1;
    check("rst_gnt", tcdm.gnt, 3'b000);
    step();
    step();
    check("rst_gnt2", tcdm.gnt, 3'b000);
    check("rst_valid", tcdm.r_valid, 3'b000);
    check("rst_rdata", tcdm.r_data, '0);

    // single port write then read
    rst = 1'b0;
    setp(0, 1'b1, 32'h40, 1'b0, 4'hF, 32'hDEADBEEF);
    #1 check("wr_gnt", tcdm.gnt, 3'b001);
    step();
    check("wr_valid", tcdm.r_valid, 3'b001);
    check("wr_rdata0", tcdm.r_data[0], 32'h0);
    setp(0, 1'b1, 32'h40, 1'b1, 4'hF, '0);
    #1 check("rd_gnt", tcdm.gnt, 3'b001);
    step();
    check("rd_valid", tcdm.r_valid, 3'b001);
    check("rd_data", tcdm.r_data[0], 32'hDEADBEEF);
    idle_all();
    step();
    check("rd_valid_drop", tcdm.r_valid, 3'b000);
    check("rd_data_hold", tcdm.r_data[0], 32'hDEADBEEF);

    // byte enables
    setp(0, 1'b1, 32'h0, 1'b0, 4'hF, 32'h11223344);
    step();
    setp(0, 1'b1, 32'h0, 1'b0, 4'b0101, 32'hAABBCCDD);
    step();
    setp(0, 1'b1, 32'h0, 1'b1, 4'h0, '0);
    step();
    check("be_data", tcdm.r_data[0], 32'h11BB33DD);

    // preload bank 0 rows 1 and 2, then park bank-0 pointer at port 0 via port 2
    setp(0, 1'b1, 32'h10, 1'b0, 4'hF, 32'h10101010);
    step();
    setp(0, 1'b1, 32'h20, 1'b0, 4'hF, 32'h20202020);
    step();
    idle_all();
    setp(2, 1'b1, 32'h0, 1'b1, 4'h0, '0);
    #1 check("p2_gnt", tcdm.gnt, 3'b100);
    step();
    check("p2_data", tcdm.r_data[2], 32'h11BB33DD);

    // conflict on bank 0 with round-robin rotation
    exp_val[0] = 32'h11BB33DD;
    exp_val[1] = 32'h10101010;
    exp_val[2] = 32'h20202020;
    setp(0, 1'b1, 32'h0,  1'b1, 4'h0, '0);
    setp(1, 1'b1, 32'h10, 1'b1, 4'h0, '0);
    setp(2, 1'b1, 32'h20, 1'b1, 4'h0, '0);
    for (int unsigned k = 0; k < 6; k++) begin
      w = k % 3;
      onehot = 3'(1 << w);
      #1 check("rr_gnt", tcdm.gnt, onehot);
      step();
      check("rr_valid", tcdm.r_valid, onehot);
      check("rr_data", tcdm.r_data[w], exp_val[w]);
    end

    // parallel banks: writes to banks 3,1,2 then reads of banks 0,1,2
    setp(0, 1'b1, 32'hC, 1'b0, 4'hF, 32'hCCCCCCCC);
    setp(1, 1'b1, 32'h4, 1'b0, 4'hF, 32'h44444444);
    setp(2, 1'b1, 32'h8, 1'b0, 4'hF, 32'h88888888);
    #1 check("par_wr_gnt", tcdm.gnt, 3'b111);
    step();
    check("par_wr_data", tcdm.r_data, '0);
    setp(0, 1'b1, 32'h0, 1'b1, 4'h0, '0);
    setp(1, 1'b1, 32'h4, 1'b1, 4'h0, '0);
    setp(2, 1'b1, 32'h8, 1'b1, 4'h0, '0);
    #1 check("par_rd_gnt", tcdm.gnt, 3'b111);
    step();
    check("par_valid", tcdm.r_valid, 3'b111);
    check("par_data", tcdm.r_data, {32'h88888888, 32'h44444444, 32'h11BB33DD});

    // stall port 1 while port 0 hammers the same bank
    idle_all();
    setp(0, 1'b1, 32'h0,  1'b1, 4'h0, '0);
    setp(1, 1'b1, 32'h10, 1'b1, 4'h0, '0);
    stall = 3'b010;
    for (int unsigned k = 0; k < 4; k++) begin
      #1 check("stall_gnt", tcdm.gnt, 3'b001);
      step();
      check("stall_valid", tcdm.r_valid, 3'b001);
    end
    stall = '0;
    #1 check("unstall_gnt", tcdm.gnt, 3'b010);
    step();
    check("unstall_valid", tcdm.r_valid, 3'b010);
    check("unstall_data", tcdm.r_data[1], 32'h10101010);

    // reset in the middle of a read burst
    setp(1, 1'b1, 32'h4, 1'b1, 4'h0, '0);
    #1 check("pre_rst_gnt", tcdm.gnt, 3'b011);
    step();
    check("pre_rst_valid", tcdm.r_valid, 3'b011);
    rst = 1'b1;
    #1 check("in_rst_gnt", tcdm.gnt, 3'b000);
    step();
    check("rst1_valid", tcdm.r_valid, 3'b000);
    check("rst1_data", tcdm.r_data, '0);
    check("rst1_gnt", tcdm.gnt, 3'b000);
    step();
    check("rst2_valid", tcdm.r_valid, 3'b000);
    check("rst2_data", tcdm.r_data, '0);
    rst = 1'b0;
    #1 check("post_rst_gnt", tcdm.gnt, 3'b011);
    step();
    check("post_rst_valid", tcdm.r_valid, 3'b011);
    check("post_rst_data0", tcdm.r_data[0], 32'h11BB33DD);
    check("post_rst_data1", tcdm.r_data[1], 32'h44444444);
    idle_all();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
